countdown_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 21 ++
 rtl/sec_tick_gen.sv | 29 ++
 rtl/countdown_timer.sv | 104 ++++++++++
 tb/tb_countdown_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared status encodings, widths and helpers for the mm:ss timers
package timer_pkg;

    localparam int MIN_W = 8;
    localparam int SEC_W = 6;

    localparam logic [SEC_W-1:0] MAX_SECONDS = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } status_t;

    // Presets above 59 seconds are pinned to 59 rather than rolled into minutes
    function automatic logic [SEC_W-1:0] clamp_seconds(input logic [SEC_W-1:0] value);
        return (value > MAX_SECONDS) ? MAX_SECONDS : value;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-second prescaler with enable and synchronous clear
module sec_tick_gen #(
    parameter int TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count;

    // Count 0..TICKS-1 while enabled, wrap on the terminal cycle, hold otherwise
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    // Tick only fires when the count is actually allowed to advance this edge
    assign tick = en && (count == LAST);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable mm:ss countdown with pause, clear and expiry pulse
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MIN_W-1:0] set_minutes,
    input  logic [SEC_W-1:0] set_seconds,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic [1:0]       status,
    output logic             expired
);

    status_t state;
    logic    load_ok;
    logic    count_zero;
    logic    presc_clr;
    logic    presc_en;
    logic    tick;

    assign load_ok    = load && (state != ST_RUNNING);
    assign count_zero = (minutes == '0) && (seconds == '0);

    // Prescaler restarts on clear, accepted load or a fresh start from IDLE;
    // it only advances while RUNNING and not being stopped this edge
    assign presc_clr = clear || load_ok || ((state == ST_IDLE) && start);
    assign presc_en  = (state == ST_RUNNING) && !stop && !clear;

    sec_tick_gen #(
        .TICKS (TICKS_PER_SEC)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    // Control FSM and mm:ss down-counter; priority rst > clear > load > stop > start
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            minutes <= '0;
            seconds <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear) begin
                state   <= ST_IDLE;
                minutes <= '0;
                seconds <= '0;
            end else if (load_ok) begin
                state   <= ST_IDLE;
                minutes <= set_minutes;
                seconds <= clamp_seconds(set_seconds);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!stop && start && !count_zero) begin
                            state <= ST_RUNNING;
                        end
                    end
                    ST_RUNNING: begin
                        if (stop) begin
                            state <= ST_PAUSED;
                        end else if (tick) begin
                            if (seconds != '0) begin
                                seconds <= seconds - SEC_W'(1);
                            end else if (minutes != '0) begin
                                seconds <= MAX_SECONDS;
                                minutes <= minutes - MIN_W'(1);
                            end
                            if ((minutes == '0) && (seconds <= SEC_W'(1))) begin
                                state   <= ST_EXPIRED;
                                expired <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!stop && start) begin
                            state <= ST_RUNNING;
                        end
                    end
                    ST_EXPIRED: begin
                        state <= ST_EXPIRED;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign status = state;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - vector table plus directed sequences for countdown_timer
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] set_minutes;
    logic [5:0] set_seconds;
    logic       start;
    logic       stop;
    logic       clear;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic       expired;

    int n_cmp = 0;
    int n_bad = 0;

    countdown_timer #(
        .TICKS_PER_SEC (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .set_minutes (set_minutes),
        .set_seconds (set_seconds),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .minutes     (minutes),
        .seconds     (seconds),
        .status      (status),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] sm;
        logic [5:0] ss;
        logic       st;
        logic       sp;
        logic       cl;
        logic [7:0] em;
        logic [5:0] es;
        logic [1:0] est;
        logic       eexp;
    } vec_t;

    vec_t vecs [18];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] sm, input logic [5:0] ss,
                         input logic st, input logic sp, input logic cl);
        load        = ld;
        set_minutes = sm;
        set_seconds = ss;
        start       = st;
        stop        = sp;
        clear       = cl;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] em, input logic [5:0] es,
                             input logic [1:0] est, input logic eexp);
        check({tag, ".minutes"}, 32'(minutes), 32'(em));
        check({tag, ".seconds"}, 32'(seconds), 32'(es));
        check({tag, ".status"},  32'(status),  32'(est));
        check({tag, ".expired"}, 32'(expired), 32'(eexp));
    endtask

    // One edge with the given inputs, then inputs return to idle
    task automatic pulse(input logic ld, input logic [7:0] sm, input logic [5:0] ss,
                         input logic st, input logic sp, input logic cl);
        drive(ld, sm, ss, st, sp, cl);
        cyc();
        drive(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //            ld    sm     ss     st    sp    cl    em     es     est    exp
        vecs[0]  = '{1'b1, 8'd0,  6'd63, 1'b0, 1'b0, 1'b0, 8'd0,  6'd59, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd0,  6'd59, 2'b00, 1'b0};
        vecs[2]  = '{1'b1, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd0,  6'd0,  2'b00, 1'b0};
        vecs[3]  = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b0, 1'b0, 8'd0,  6'd0,  2'b00, 1'b0};
        vecs[4]  = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd0,  6'd0,  2'b00, 1'b0};
        vecs[5]  = '{1'b0, 8'd9,  6'd9,  1'b0, 1'b0, 1'b0, 8'd0,  6'd0,  2'b00, 1'b0};
        vecs[6]  = '{1'b1, 8'd0,  6'd10, 1'b0, 1'b0, 1'b0, 8'd0,  6'd10, 2'b00, 1'b0};
        vecs[7]  = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b0, 1'b0, 8'd0,  6'd10, 2'b01, 1'b0};
        vecs[8]  = '{1'b1, 8'd5,  6'd5,  1'b0, 1'b0, 1'b0, 8'd0,  6'd10, 2'b01, 1'b0};
        vecs[9]  = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd0,  6'd10, 2'b01, 1'b0};
        vecs[10] = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b1, 1'b0, 8'd0,  6'd10, 2'b10, 1'b0};
        vecs[11] = '{1'b1, 8'd1,  6'd0,  1'b0, 1'b0, 1'b0, 8'd1,  6'd0,  2'b00, 1'b0};
        vecs[12] = '{1'b0, 8'd0,  6'd0,  1'b1, 1'b0, 1'b0, 8'd1,  6'd0,  2'b01, 1'b0};
        vecs[13] = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd1,  6'd0,  2'b01, 1'b0};
        vecs[14] = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd1,  6'd0,  2'b01, 1'b0};
        vecs[15] = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd1,  6'd0,  2'b01, 1'b0};
        vecs[16] = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b0, 8'd0,  6'd59, 2'b01, 1'b0};
        vecs[17] = '{1'b0, 8'd0,  6'd0,  1'b0, 1'b0, 1'b1, 8'd0,  6'd0,  2'b00, 1'b0};

        rst = 1'b1;
        drive(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        check_out("reset", 8'd0, 6'd0, 2'b00, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].ld, vecs[i].sm, vecs[i].ss, vecs[i].st, vecs[i].sp, vecs[i].cl);
            cyc();
            check_out($sformatf("vec%0d", i), vecs[i].em, vecs[i].es, vecs[i].est, vecs[i].eexp);
        end
        drive(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);

        // 00:03 countdown: decrements 4, 8, 12 cycles after start, one expiry pulse
        pulse(1'b1, 8'd0, 6'd3, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check_out($sformatf("cd3_k%0d", k), 8'd0, 6'(3 - k / 4),
                      (k == 12) ? 2'b11 : 2'b01, (k == 12));
        end
        for (int k = 0; k < 20; k++) begin
            cyc();
            check_out($sformatf("cd3_hold%0d", k), 8'd0, 6'd0, 2'b11, 1'b0);
        end
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        check_out("exp_start", 8'd0, 6'd0, 2'b11, 1'b0);
        pulse(1'b1, 8'd2, 6'd30, 1'b0, 1'b0, 1'b0);
        check_out("exp_load", 8'd2, 6'd30, 2'b00, 1'b0);

        // Pause mid-second, resume keeps the fraction: decrement 2 cycles after resume
        pulse(1'b1, 8'd0, 6'd5, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc();
        pulse(1'b0, 8'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check_out($sformatf("paused%0d", k), 8'd0, 6'd5, 2'b10, 1'b0);
        end
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        check_out("resume_r0", 8'd0, 6'd5, 2'b01, 1'b0);
        cyc();
        check_out("resume_r1", 8'd0, 6'd5, 2'b01, 1'b0);
        cyc();
        check_out("resume_r2", 8'd0, 6'd4, 2'b01, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b1);

        // Clear on the would-be expiry edge suppresses the pulse
        pulse(1'b1, 8'd0, 6'd1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc();
        pulse(1'b0, 8'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        check_out("clr_expiry", 8'd0, 6'd0, 2'b00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_out($sformatf("clr_after%0d", k), 8'd0, 6'd0, 2'b00, 1'b0);
        end

        // Stop on a terminal-tick edge: no decrement; next start decrements one edge later
        pulse(1'b1, 8'd0, 6'd2, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc();
        pulse(1'b0, 8'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        check_out("stop_tick", 8'd0, 6'd2, 2'b10, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        check_out("start_stop", 8'd0, 6'd2, 2'b10, 1'b0);
        pulse(1'b0, 8'd0, 6'd0, 1'b1, 1'b0, 1'b0);
        check_out("restart_r0", 8'd0, 6'd2, 2'b01, 1'b0);
        cyc();
        check_out("restart_r1", 8'd0, 6'd1, 2'b01, 1'b0);

        // Reset while running
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_out("rst_run", 8'd0, 6'd0, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
